// File: rtl/adder_seq_n.sv
// adder_seq_n: multi-cycle execute-stage adder.
// Carry chain split into SLICES slices, one slice per clock.
module adder_seq_n #(
    parameter int N      = 32,
    parameter int SLICES = 4
) (
    input  logic         iCLOCK,
    input  logic         iRESET_SYNC,
    input  logic         iREQ,
    input  logic [4:0]   iCMD,
    input  logic [N-1:0] iDATA_0,
    input  logic [N-1:0] iDATA_1,
    input  logic         iCARRY,
    input  logic         iCANCEL,
    input  logic         iWAIT,
    output logic         oBUSY,
    output logic         oVALID,
    output logic [N-1:0] oDATA,
    output logic         oSF,
    output logic         oOF,
    output logic         oCF,
    output logic         oPF,
    output logic         oZF
);

    localparam int W  = N / SLICES;
    localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    localparam logic [4:0] CMD_ADD    = 5'd0;
    localparam logic [4:0] CMD_SUB    = 5'd1;
    localparam logic [4:0] CMD_NEG    = 5'd2;
    localparam logic [4:0] CMD_COUT   = 5'd3;
    localparam logic [4:0] CMD_SEXT8  = 5'd4;
    localparam logic [4:0] CMD_SEXT16 = 5'd5;
    localparam logic [4:0] CMD_ADC    = 5'd6;
    localparam logic [4:0] CMD_SBC    = 5'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [N-1:0]  op0;
    logic [N-1:0]  op1;
    logic [N-1:0]  res;
    logic [N-1:0]  resNext;
    logic [4:0]    cmd;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [W:0]    sliceSum;
    int            base;

    logic [N-1:0]  prep0;
    logic [N-1:0]  prep1;
    logic          prepCin;

    logic          accept;
    logic          lastSlice;

    logic [N-1:0]  dataFinal;
    logic          sfFinal;
    logic          ofFinal;
    logic          cfFinal;
    logic          pfFinal;
    logic          zfFinal;

    assign accept    = (state == IDLE) && iREQ && !iCANCEL;
    assign lastSlice = (state == CALC) && (cnt == LAST);

    // State register.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: cancel always returns to IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = CALC;
                end
            end
            CALC: begin
                if (iCANCEL) begin
                    stateNext = IDLE;
                end else if (lastSlice) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (iCANCEL || !iWAIT) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        oBUSY  = (state != IDLE);
        oVALID = (state == DONE);
    end

    // Operand preparation: subtraction and negation become additions.
    always_comb begin
        prep0   = iDATA_0;
        prep1   = iDATA_1;
        prepCin = 1'b0;
        case (iCMD)
            CMD_ADC: begin
                prepCin = iCARRY;
            end
            CMD_SUB: begin
                prep1   = ~iDATA_1;
                prepCin = 1'b1;
            end
            CMD_SBC: begin
                prep1   = ~iDATA_1;
                prepCin = iCARRY;
            end
            CMD_NEG: begin
                prep0   = ~iDATA_0;
                prep1   = '0;
                prepCin = 1'b1;
            end
            default: ;
        endcase
    end

    // One W-bit slice of the carry chain, selected by the slice counter.
    always_comb begin
        base     = int'(cnt) * W;
        sliceSum = {1'b0, op0[base +: W]}
                 + {1'b0, op1[base +: W]}
                 + {{W{1'b0}}, carry};
        resNext  = res;
        resNext[base +: W] = sliceSum[W-1:0];
    end

    // Final result and flags, valid when the last slice is computed.
    always_comb begin
        dataFinal = '0;
        sfFinal   = 1'b0;
        ofFinal   = 1'b0;
        cfFinal   = 1'b0;
        pfFinal   = 1'b0;
        zfFinal   = 1'b0;
        case (cmd)
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC, CMD_COUT: begin
                dataFinal = resNext;
                if (cmd == CMD_COUT) begin
                    dataFinal = {{(N-1){1'b0}}, sliceSum[W]};
                end
                sfFinal = resNext[N-1];
                ofFinal = (op0[N-1] == op1[N-1])
                       && (resNext[N-1] != op0[N-1]);
                cfFinal = sliceSum[W];
                pfFinal = resNext[0];
                zfFinal = (resNext == '0);
            end
            CMD_NEG: begin
                dataFinal = resNext;
            end
            CMD_SEXT8: begin
                dataFinal = {{(N-8){op1[7]}}, op1[7:0]};
            end
            CMD_SEXT16: begin
                dataFinal = {{(N-16){op1[15]}}, op1[15:0]};
            end
            default: ;
        endcase
    end

    // Operand latch at accept, then one slice per clock in CALC.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            op0   <= '0;
            op1   <= '0;
            res   <= '0;
            cmd   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            op0   <= prep0;
            op1   <= prep1;
            res   <= '0;
            cmd   <= iCMD;
            carry <= prepCin;
            cnt   <= '0;
        end else if (state == CALC) begin
            res   <= resNext;
            carry <= sliceSum[W];
            cnt   <= lastSlice ? '0 : cnt + 1'b1;
        end
    end

    // Result registers: updated only on an uncancelled completion.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            oDATA <= '0;
            oSF   <= 1'b0;
            oOF   <= 1'b0;
            oCF   <= 1'b0;
            oPF   <= 1'b0;
            oZF   <= 1'b0;
        end else if (lastSlice && !iCANCEL) begin
            oDATA <= dataFinal;
            oSF   <= sfFinal;
            oOF   <= ofFinal;
            oCF   <= cfFinal;
            oPF   <= pfFinal;
            oZF   <= zfFinal;
        end
    end

endmodule
